// File: rtl/pipe_reg_skid.sv
// Pipeline stage register with valid/ready handshake and a 2-entry skid buffer; optional stall counter (PIPE_REG_STALL_CNT_EN).
// Latency 1 cycle from push to out_data; in_ready is registered so there is no comb path from out_ready.
// Backpressure: a second entry parks in the skid register, then in_ready drops until the main entry drains.
module pipe_reg_skid #(
    parameter int                 WIDTH     = 32,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0,
    parameter int                 CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data
`ifdef PIPE_REG_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   main_q, main_d;
    logic [WIDTH-1:0]   skid_q, skid_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               push, pop;

    assign push      = in_valid & in_ready_q;
    assign pop       = out_valid_q & out_ready;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = RESET_VAL;
            skid_d  = RESET_VAL;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        state_d = ST_ONE;
                        main_d  = in_data;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        main_d = in_data;
                    end else if (push) begin
                        state_d = ST_TWO;
                        skid_d  = in_data;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so the only move is draining main and promoting skid
                    if (pop) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
        in_ready_d  = (state_d != ST_TWO);
        out_valid_d = (state_d != ST_EMPTY);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_EMPTY;
            main_q      <= RESET_VAL;
            skid_q      <= RESET_VAL;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef PIPE_REG_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (flush) begin
            stall_cnt_d = '0;
        end else if (out_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_reg_skid.sv
// Directed bench for pipe_reg_skid (WIDTH=32, RESET_VAL=0); stall counter steps run when PIPE_REG_STALL_CNT_EN is defined.
module tb_pipe_reg_skid;

    localparam int WIDTH = 32;
`ifdef PIPE_REG_STALL_CNT_EN
    localparam int CNT_W = 4;
`else
    localparam int CNT_W = 16;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_data;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_data;
`ifdef PIPE_REG_STALL_CNT_EN
    logic [CNT_W-1:0]  stall_cnt;
`endif

    int errors = 0;
    int checks = 0;

    pipe_reg_skid #(
        .WIDTH     (WIDTH),
        .RESET_VAL ('0),
        .CNT_W     (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef PIPE_REG_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Upstream must keep in_data stable while a presented entry is stalled.
    logic              prev_stalled = 1'b0;
    logic [WIDTH-1:0]  prev_data    = '0;
    always @(posedge clk) begin
        if (reset && prev_stalled && in_valid && !flush) begin
            checks++;
            assert (in_data === prev_data) else begin
                errors++;
                $error("FAIL in_data_stable observed=%0h expected=%0h", in_data, prev_data);
            end
        end
        prev_stalled = reset && in_valid && !in_ready;
        prev_data    = in_data;
    end

    initial begin
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        tick(); tick();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_out_data",  out_data,           32'd0);
        reset = 1'b1;

        // Streaming at full rate
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = i;
            tick();
            check($sformatf("stream_data_%0d", i), out_data, i);
            check($sformatf("stream_vld_%0d", i), {31'd0, out_valid}, 32'd1);
            check($sformatf("stream_rdy_%0d", i), {31'd0, in_ready}, 32'd1);
        end
        in_valid = 1'b0;
        tick();
        check("stream_drained", {31'd0, out_valid}, 32'd0);

        // Back-pressure into the skid register
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hA;
        tick();
        check("bp_one_rdy", {31'd0, in_ready}, 32'd1);
        in_data = 32'hB;
        tick();
        check("bp_two_rdy",  {31'd0, in_ready}, 32'd0);
        check("bp_two_data", out_data,          32'hA);
        in_valid = 1'b0;
        tick();
        check("bp_hold_data", out_data, 32'hA);
        out_ready = 1'b1;
        tick();
        check("bp_pop1_data", out_data,            32'hB);
        check("bp_pop1_vld",  {31'd0, out_valid},  32'd1);
        check("bp_pop1_rdy",  {31'd0, in_ready},   32'd1);
        tick();
        check("bp_empty", {31'd0, out_valid}, 32'd0);

        // Flush with two entries held and a pending input
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h21;
        tick();
        in_data = 32'h22;
        tick();
        check("fl_two_rdy", {31'd0, in_ready}, 32'd0);
        in_data = 32'hC; flush = 1'b1; out_ready = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_vld",  {31'd0, out_valid}, 32'd0);
        check("fl_data", out_data,           32'd0);
        check("fl_rdy",  {31'd0, in_ready},  32'd1);
        check("fl_skid", dut.skid_q,         32'd0);
        tick();
        check("fl_no_0xC", {31'd0, out_valid}, 32'd0);

        // Simultaneous push and pop while ONE
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h5;
        tick();
        check("pp_main5", out_data, 32'h5);
        in_data = 32'h6; out_ready = 1'b1;
        tick();
        check("pp_main6", out_data,           32'h6);
        check("pp_vld",   {31'd0, out_valid}, 32'd1);
        check("pp_rdy",   {31'd0, in_ready},  32'd1);
        check("pp_skid",  dut.skid_q,         32'd0);
        in_valid = 1'b0;
        tick();
        check("pp_empty", {31'd0, out_valid}, 32'd0);

`ifdef PIPE_REG_STALL_CNT_EN
        // Stall counter saturation and flush clear
        check("sc_start", {28'd0, stall_cnt}, 32'd0);
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h7;
        tick();
        in_valid = 1'b0;
        check("sc_first", {28'd0, stall_cnt}, 32'd0);
        for (int i = 0; i < 20; i++) tick();
        check("sc_sat", {28'd0, stall_cnt}, 32'd15);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("sc_flush", {28'd0, stall_cnt}, 32'd0);
        out_ready = 1'b1;
`endif

        // Async reset mid-stream with two entries held
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h11;
        tick();
        in_data = 32'h22;
        tick();
        in_valid = 1'b0;
        check("rs_two_rdy", {31'd0, in_ready}, 32'd0);
        #2;
        reset = 1'b0;
        #1;
        check("rs_vld",  {31'd0, out_valid}, 32'd0);
        check("rs_rdy",  {31'd0, in_ready},  32'd1);
        check("rs_data", out_data,           32'd0);
        tick();
        reset = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 32'h33;
        tick();
        in_valid = 1'b0;
        check("rs_first_push", out_data,           32'h33);
        check("rs_first_vld",  {31'd0, out_valid}, 32'd1);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
